simon_playback: RTL and testbench
=================================

SIMON_PLAYBACK -- requirements
Module: simon_playback

Interface
REQ-001 SHALL have parameter ON_MS, default 400, LED/tone on-time per step in milliseconds.
REQ-002 SHALL have parameter GAP_MS, default 100, dark time after each step in milliseconds.
REQ-003 SHALL have parameter MAX_STEPS, default 32, longest playable sequence.
REQ-004 SHALL have parameter ADDR_W, default 5, width of step_addr.
REQ-005 clk  in  1  single clock.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 ticks_per_milli  in  6  clk cycles per millisecond.
REQ-008 start  in  1  one-cycle request to play a sequence.
REQ-009 abort  in  1  stop playback immediately.
REQ-010 seq_len  in  6  number of steps to play, sampled on accepted start.
REQ-011 step_req  out  1  fetch request to sequence memory.
REQ-012 step_addr  out  ADDR_W  step index being fetched.
REQ-013 step_ack  in  1  memory returns step_color this cycle.
REQ-014 step_color  in  2  color of fetched step (0..3).
REQ-015 led  out  4  one-hot LED drive.
REQ-016 tone_en  out  1  enables the tone generator.
REQ-017 tone_sel  out  2  color selecting the tone pitch.
REQ-018 busy  out  1  high from the cycle after an accepted start until done.
REQ-019 done  out  1  one-cycle pulse at the end of normal completion.

Function
REQ-020 SHALL implement the states IDLE, FETCH, ON, GAP and DONE.
REQ-021 start seen in IDLE SHALL latch min(seq_len, MAX_STEPS) and clear the step index; start SHALL be ignored in any other state.
REQ-022 On accepted start with a nonzero latched length, FETCH SHALL be entered next cycle with step_req=1 and step_addr=0.
REQ-023 On accepted start with a latched length of 0, DONE SHALL be entered next cycle with no fetch.
REQ-024 step_req SHALL stay high and step_addr stable until step_ack; ack with step_req low SHALL be ignored.
REQ-025 On the ack cycle, step_color SHALL be captured; ON SHALL be entered next cycle with led=1<<color, tone_sel=color and tone_en=1.
REQ-026 ON SHALL last exactly ON_MS*T cycles and GAP exactly GAP_MS*T cycles, where T=ticks_per_milli and T=0 is treated as 1.
REQ-027 During GAP, led=0 and tone_en=0.
REQ-028 GAP exit SHALL increment the index; if index<length go to FETCH, else go to DONE.
REQ-029 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-030 abort SHALL take priority over start and all transitions: IDLE next cycle, led/tone_en/step_req/busy=0, no done pulse.
REQ-031 ticks_per_milli SHALL be sampled only at each ms-timer load; a change mid-interval affects the next interval only.
REQ-032 led SHALL be one-hot or zero at all times.

Reset
REQ-033 Reset SHALL apply on the clk edge while rst_n=0, including mid-playback.
REQ-034 After reset: state IDLE, led=0, tone_en=0, tone_sel=0, step_req=0, step_addr=0, busy=0, done=0, all timer counters 0.

Structure
REQ-035 Package simon_pkg SHALL hold the 2-bit color type, the playback state enum and the default ON_MS/GAP_MS constants.
REQ-036 Sub-module simon_ms_timer SHALL provide the ms prescaler (counts to T) and the ms down-counter, with load and expired signals.
REQ-037 RTL SHALL be synthesizable and latch-free, at 120-400 lines total.

Verification (ON_MS=2, GAP_MS=1, T=3 unless stated)
REQ-038 seq_len=2, colors {2,0}, ack 1 cycle after req: led=4'b0100 for 6 cycles, 0 for 3 cycles, then 4'b0001 for 6 cycles, 0 for 3 cycles; one done pulse; step_addr 0 then 1.
REQ-039 seq_len=0: done one cycle after start; step_req never asserted.
REQ-040 seq_len=40: exactly 32 fetches, step_addr 0..31, then done.
REQ-041 abort in the 3rd cycle of ON for step 0: next cycle led=0, busy=0, no done; a new start 2 cycles later plays from step_addr 0.
REQ-042 ack delayed 5 cycles with a second start pulse mid-playback: step_addr held, start ignored, timing per REQ-038.
REQ-043 T=0 and rst_n low mid-GAP: ON lasts 2 cycles; after reset all outputs per REQ-034.

Source files
------------

// File: rtl/simon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simon_pkg                                                                  |
// | Shared types and constants for the Simon sequence playback block.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package simon_pkg;

    typedef logic [1:0] color_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ON    = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int c_default_on_ms  = 400;
    localparam int c_default_gap_ms = 100;

    // Timer field widths: ms counter, prescaler (matches ticks_per_milli), step length
    localparam int c_ms_w  = 16;
    localparam int c_tpm_w = 6;
    localparam int c_len_w = 6;

    function automatic logic [3:0] color_to_led(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage : simon_pkg
`default_nettype wire

// File: rtl/simon_ms_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simon_ms_timer                                                             |
// | Millisecond prescaler plus ms down-counter; expired marks the last cycle.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module simon_ms_timer
    import simon_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [c_ms_w-1:0]  i_ms_count,
    input  logic [c_tpm_w-1:0] i_ticks_per_milli,
    output logic               o_expired
);

    logic [c_tpm_w-1:0] r_pre;
    logic [c_tpm_w-1:0] r_tlim;
    logic [c_ms_w-1:0]  r_ms;
    logic [c_tpm_w-1:0] w_tlim_eff;
    logic               w_pre_wrap;

    // A zero tick rate would stall the prescaler, so it counts as one tick per ms
    assign w_tlim_eff = (i_ticks_per_milli == '0) ? c_tpm_w'(1) : i_ticks_per_milli;
    assign w_pre_wrap = (r_pre == r_tlim - c_tpm_w'(1));
    assign o_expired  = (r_ms == '0) || ((r_ms == c_ms_w'(1)) && w_pre_wrap);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_tlim <= '0;
            r_ms   <= '0;
        end else if (i_load) begin
            r_pre  <= '0;
            r_tlim <= w_tlim_eff;
            r_ms   <= i_ms_count;
        end else if (r_ms != '0) begin
            if (w_pre_wrap) begin
                r_pre <= '0;
                r_ms  <= r_ms - c_ms_w'(1);
            end else begin
                r_pre <= r_pre + c_tpm_w'(1);
            end
        end
    end

endmodule : simon_ms_timer
`default_nettype wire

// File: rtl/simon_playback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simon_playback                                                             |
// | Fetches a color sequence from memory and plays it on LEDs and tone.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module simon_playback
    import simon_pkg::*;
#(
    parameter int ON_MS     = c_default_on_ms,
    parameter int GAP_MS    = c_default_gap_ms,
    parameter int MAX_STEPS = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        ticks_per_milli,
    input  logic              start,
    input  logic              abort,
    input  logic [5:0]        seq_len,
    output logic              step_req,
    output logic [ADDR_W-1:0] step_addr,
    input  logic              step_ack,
    input  logic [1:0]        step_color,
    output logic [3:0]        led,
    output logic              tone_en,
    output logic [1:0]        tone_sel,
    output logic              busy,
    output logic              done
);

    state_t             r_state;
    state_t             w_next;
    logic [c_len_w-1:0] r_len;
    logic [c_len_w-1:0] r_idx;
    logic [c_len_w-1:0] w_len_clamped;
    color_t             r_color;
    logic               w_accept;
    logic               w_capture;
    logic               w_advance;
    logic               w_load;
    logic               w_expired;
    logic [c_ms_w-1:0]  w_ms_count;

    assign w_len_clamped = (int'(seq_len) > MAX_STEPS) ? c_len_w'(MAX_STEPS) : seq_len;

    simon_ms_timer u_timer (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_load            (w_load),
        .i_ms_count        (w_ms_count),
        .i_ticks_per_milli (ticks_per_milli),
        .o_expired         (w_expired)
    );

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_advance  = 1'b0;
        w_load     = 1'b0;
        w_ms_count = c_ms_w'(ON_MS);
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (w_len_clamped == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (step_ack) begin
                    w_capture = 1'b1;
                    w_load    = 1'b1;
                    w_next    = ST_ON;
                end
            end
            ST_ON: begin
                if (w_expired) begin
                    w_load     = 1'b1;
                    w_ms_count = c_ms_w'(GAP_MS);
                    w_next     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_expired) begin
                    w_advance = 1'b1;
                    w_next    = ((r_idx + c_len_w'(1)) < r_len) ? ST_FETCH : ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        // Abort overrides every transition and suppresses all datapath updates
        if (abort) begin
            w_next    = ST_IDLE;
            w_accept  = 1'b0;
            w_capture = 1'b0;
            w_advance = 1'b0;
            w_load    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_len <= w_len_clamped;
                r_idx <= '0;
            end
            if (w_capture) begin
                r_color <= step_color;
            end
            if (w_advance) begin
                r_idx <= r_idx + c_len_w'(1);
            end
        end
    end

    generate
        if (ADDR_W <= c_len_w) begin : g_addr_trunc
            assign step_addr = r_idx[ADDR_W-1:0];
        end else begin : g_addr_ext
            assign step_addr = {{(ADDR_W - c_len_w){1'b0}}, r_idx};
        end
    endgenerate

    always_comb begin
        step_req = (r_state == ST_FETCH);
        led      = 4'b0000;
        tone_en  = 1'b0;
        tone_sel = 2'b00;
        busy     = (r_state == ST_FETCH) || (r_state == ST_ON) || (r_state == ST_GAP);
        done     = (r_state == ST_DONE);
        if (r_state == ST_ON) begin
            led      = color_to_led(r_color);
            tone_en  = 1'b1;
            tone_sel = r_color;
        end
    end

endmodule : simon_playback
`default_nettype wire

// File: tb/tb_simon_playback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_simon_playback                                                          |
// | Scenario-driven bench comparing simon_playback against a trace model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_simon_playback;

    localparam int ON_MS  = 2;
    localparam int GAP_MS = 1;
    localparam int MAXS   = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] ticks_per_milli = 6'd3;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] seq_len = 6'd0;
    logic       step_req;
    logic [4:0] step_addr;
    logic       step_ack = 1'b0;
    logic [1:0] step_color = 2'd0;
    logic [3:0] led;
    logic       tone_en;
    logic [1:0] tone_sel;
    logic       busy;
    logic       done;

    int vectors = 0;
    int errors  = 0;

    simon_playback #(
        .ON_MS(ON_MS), .GAP_MS(GAP_MS), .MAX_STEPS(MAXS), .ADDR_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ticks_per_milli(ticks_per_milli),
        .start(start), .abort(abort), .seq_len(seq_len),
        .step_req(step_req), .step_addr(step_addr), .step_ack(step_ack),
        .step_color(step_color), .led(led), .tone_en(tone_en),
        .tone_sel(tone_sel), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int seq_len; int tpm; bit wobble; int ack_min; int ack_max;
        int col0; int col1; bit xstart; int kill_at; bit kill_rst;
    } scn_t;

    typedef struct {
        bit start; bit abort; bit rst; bit ack;
        logic [1:0] color; logic [5:0] tpm; logic [5:0] len;
    } drv_t;

    typedef struct {
        bit valid; bit chk_addr; bit chk_tsel;
        logic req; logic [4:0] addr; logic [3:0] led; logic tone;
        logic [1:0] tsel; logic busy; logic done;
    } exp_t;

    drv_t dq[$];
    exp_t eq[$];

    function automatic int eff(input logic [5:0] t);
        return (t == 6'd0) ? 1 : int'(t);
    endfunction

    function automatic drv_t fill(input scn_t s, input bit allow_start);
        drv_t d;
        d.start = allow_start && s.xstart && ($urandom_range(0, 3) == 0);
        d.abort = 1'b0;
        d.rst   = 1'b0;
        d.ack   = 1'($urandom_range(0, 1));
        d.color = 2'($urandom);
        d.tpm   = s.wobble ? 6'($urandom_range(0, 3)) : 6'(s.tpm);
        d.len   = 6'($urandom);
        return d;
    endfunction

    function automatic exp_t mk(input bit req, input int addr, input int col, input bit on,
                                input bit bsy, input bit dn, input bit after_rst);
        exp_t e;
        e.valid    = 1'b1;
        e.chk_addr = req || after_rst;
        e.chk_tsel = on || after_rst;
        e.req      = req;
        e.addr     = 5'(addr);
        e.led      = on ? 4'(1 << col) : 4'b0000;
        e.tone     = on;
        e.tsel     = on ? 2'(col) : 2'd0;
        e.busy     = bsy;
        e.done     = dn;
        return e;
    endfunction

    // Expected trace is assembled from whole playback segments: fetch wait,
    // lit interval, dark interval, done pulse, then idle.
    task automatic build(input scn_t s);
        drv_t d;
        exp_t e;
        int   len, dly, col, n, k;
        logic [5:0] last_t;
        dq.delete();
        eq.delete();
        d = fill(s, 1'b0);
        d.start = 1'b1;
        d.len   = 6'(s.seq_len);
        dq.push_back(d);
        e = mk(0, 0, 0, 0, 0, 0, 0);
        e.valid = 1'b0;
        eq.push_back(e);
        len = (s.seq_len > MAXS) ? MAXS : s.seq_len;
        for (int i = 0; i < len; i++) begin
            dly = $urandom_range(s.ack_min, s.ack_max);
            col = (i == 0 && s.col0 >= 0) ? s.col0 :
                  (i == 1 && s.col1 >= 0) ? s.col1 : int'($urandom_range(0, 3));
            last_t = 6'd1;
            for (int j = 0; j <= dly; j++) begin
                d = fill(s, 1'b1);
                d.ack = (j == dly);
                if (j == dly) begin
                    d.color = 2'(col);
                    last_t  = d.tpm;
                end
                dq.push_back(d);
                eq.push_back(mk(1, i, 0, 0, 1, 0, 0));
            end
            n = ON_MS * eff(last_t);
            for (int j = 0; j < n; j++) begin
                d = fill(s, 1'b1);
                last_t = d.tpm;
                dq.push_back(d);
                eq.push_back(mk(0, 0, col, 1, 1, 0, 0));
            end
            n = GAP_MS * eff(last_t);
            for (int j = 0; j < n; j++) begin
                dq.push_back(fill(s, 1'b1));
                eq.push_back(mk(0, 0, 0, 0, 1, 0, 0));
            end
        end
        dq.push_back(fill(s, 1'b1));
        eq.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        for (int j = 0; j < 2; j++) begin
            dq.push_back(fill(s, 1'b0));
            eq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end
        k = s.kill_at;
        if (k == -2) k = $urandom_range(0, eq.size() - 3);
        if (k >= 0) begin
            while (eq.size() > k + 1) void'(eq.pop_back());
            while (dq.size() > k + 1) void'(dq.pop_back());
            d = dq[k];
            d.abort = !s.kill_rst;
            d.rst   = s.kill_rst;
            dq[k] = d;
            dq.push_back(fill(s, 1'b0));
            eq.push_back(mk(0, 0, 0, 0, 0, 0, s.kill_rst));
        end
    endtask

    task automatic check(input string nm, input int cyc, input exp_t e);
        logic [14:0] act, want, mask;
        act  = {step_req, step_addr, led, tone_en, tone_sel, busy, done};
        want = {e.req, e.addr, e.led, e.tone, e.tsel, e.busy, e.done};
        mask = {1'b1, {5{e.chk_addr}}, 4'hF, 1'b1, {2{e.chk_tsel}}, 2'b11};
        vectors++;
        if ((act & mask) !== (want & mask)) begin
            errors++;
            $display("FAIL %s cyc%0d {req,addr,led,tone,sel,busy,done} got %b want %b (mask %b)",
                     nm, cyc, act, want, mask);
        end
    endtask

    task automatic apply(input int id);
        drv_t d;
        for (int c = 0; c < eq.size(); c++) begin
            @(posedge clk);
            #1;
            d = dq[c];
            start           = d.start;
            abort           = d.abort;
            rst_n           = !d.rst;
            step_ack        = d.ack;
            step_color      = d.color;
            ticks_per_milli = d.tpm;
            seq_len         = d.len;
            @(negedge clk);
            if (eq[c].valid) check($sformatf("scn%0d", id), c, eq[c]);
        end
    endtask

    scn_t table_v[9];
    scn_t s;

    initial begin
        // seq_len tpm wob ackmin ackmax col0 col1 xstart kill_at kill_rst
        table_v[0] = '{2,  3, 0, 1, 1,  2,  0, 0, -1, 0};  // two-step basic timing
        table_v[1] = '{0,  3, 0, 1, 1, -1, -1, 0, -1, 0};  // zero length
        table_v[2] = '{40, 3, 0, 0, 1, -1, -1, 0, -1, 0};  // clamp to 32 steps
        table_v[3] = '{3,  3, 0, 1, 1, -1, -1, 0,  5, 0};  // abort in 3rd lit cycle
        table_v[4] = '{2,  3, 0, 1, 1, -1, -1, 0, -1, 0};  // restart 2 cycles later
        table_v[5] = '{2,  3, 0, 5, 5,  2,  0, 1, -1, 0};  // slow ack, stray starts
        table_v[6] = '{2,  0, 0, 1, 1, -1, -1, 0,  5, 1};  // T=0, reset in gap
        table_v[7] = '{3,  2, 0, 0, 2, -1, -1, 0,  0, 0};  // abort with start
        table_v[8] = '{3,  2, 1, 0, 2, -1, -1, 1, -1, 0};  // tick rate changes

        rst_n = 1'b0;
        start = 1'b1;
        step_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        step_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("reset", c, mk(0, 0, 0, 0, 0, 0, 1));
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end

        for (int i = 0; i < 9; i++) begin
            build(table_v[i]);
            apply(i);
        end

        for (int i = 0; i < 30; i++) begin
            s.seq_len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(33, 63))
                                                      : int'($urandom_range(0, 5));
            s.tpm      = $urandom_range(0, 4);
            s.wobble   = 1'($urandom_range(0, 1));
            s.ack_min  = 0;
            s.ack_max  = $urandom_range(0, 3);
            s.col0     = -1;
            s.col1     = -1;
            s.xstart   = 1'($urandom_range(0, 1));
            s.kill_at  = ($urandom_range(0, 3) == 0) ? -2 : -1;
            s.kill_rst = 1'($urandom_range(0, 1));
            build(s);
            apply(100 + i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_simon_playback
`default_nettype wire
